if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_if.sv | 21 ++
 rtl/if_id_buffer.sv | 68 ++++++
 tb/tb_if_id_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch/decode handshake bundle for the IF/ID buffer
interface if_id_buffer_if;
    logic [15:0] instr;
    logic [15:0] pc_plus_1;
    logic        if_valid;
    logic        flush;
    logic        id_stall;
    logic        if_stall;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus_1;
    logic        id_valid;
    logic        halt_seen;
    modport master (
        output instr, pc_plus_1, if_valid, flush, id_stall,
        input  if_stall, id_instr, id_pc_plus_1, id_valid, halt_seen
    );
    modport slave (
        input  instr, pc_plus_1, if_valid, flush, id_stall,
        output if_stall, id_instr, id_pc_plus_1, id_valid, halt_seen
    );
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry IF/ID FIFO with flush and optional halt detection (macro IFID_HLT_DETECT_EN)
module if_id_buffer (
    input logic           clk,
    input logic           rst_n,
    if_id_buffer_if.slave bus
);
    logic [15:0] instr_q [2];
    logic [15:0] pc_q    [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        halted;
    logic        push, pop;

    assign push = bus.if_valid && count_q != 2'd2 && !bus.flush && !halted;
    assign pop  = count_q != 2'd0 && !bus.id_stall && !bus.flush;

    // Pointer/count next state; flush wins over any push or pop
    always_comb begin
        wr_ptr_d = bus.flush ? 1'b0 : wr_ptr_q ^ push;
        rd_ptr_d = bus.flush ? 1'b0 : rd_ptr_q ^ pop;
        count_d  = bus.flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: outputs are masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= bus.instr;
            pc_q[wr_ptr_q]    <= bus.pc_plus_1;
        end
    end

`ifdef IFID_HLT_DETECT_EN
    logic halted_q, halted_d;

    // A pushed opcode 4'hF latches halted until flush
    always_comb halted_d = bus.flush ? 1'b0 : halted_q | (push && bus.instr[15:12] == 4'hF);

    // Halt flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign bus.id_valid     = count_q != 2'd0;
    assign bus.id_instr     = bus.id_valid ? instr_q[rd_ptr_q] : 16'h0000;
    assign bus.id_pc_plus_1 = bus.id_valid ? pc_q[rd_ptr_q] : 16'h0000;
    assign bus.if_stall     = count_q == 2'd2 || halted;
    assign bus.halt_seen    = halted;
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: scoreboard bench for if_id_buffer (honours IFID_HLT_DETECT_EN)
module tb_if_id_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] sb [$];
    logic halted_m = 1'b0;

    if_id_buffer_if bus();

    if_id_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] ei, ep;
        logic        ev, es;
        ev = sb.size() != 0;
        es = sb.size() == 2 || halted_m;
        ei = ev ? sb[0][31:16] : 16'h0000;
        ep = ev ? sb[0][15:0] : 16'h0000;
        chk({tag, ".id_valid"}, {15'd0, bus.id_valid}, {15'd0, ev});
        chk({tag, ".if_stall"}, {15'd0, bus.if_stall}, {15'd0, es});
        chk({tag, ".id_instr"}, bus.id_instr, ei);
        chk({tag, ".id_pc"}, bus.id_pc_plus_1, ep);
        chk({tag, ".halt_seen"}, {15'd0, bus.halt_seen}, {15'd0, halted_m});
    endtask

    task automatic cyc(input string tag, input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic f, input logic s);
        logic do_push, do_pop;
        bus.if_valid  = v;
        bus.instr     = i;
        bus.pc_plus_1 = p;
        bus.flush     = f;
        bus.id_stall  = s;
        check_outputs(tag);
        do_pop  = sb.size() != 0 && !s && !f;
        do_push = v && sb.size() < 2 && !f && !halted_m;
        if (f) begin
            sb.delete();
            halted_m = 1'b0;
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({i, p});
`ifdef IFID_HLT_DETECT_EN
            if (do_push && i[15:12] == 4'hF) halted_m = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_valid = 1'b0; bus.instr = '0; bus.pc_plus_1 = '0; bus.flush = 1'b0; bus.id_stall = 1'b0;
        #2;
        check_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("post_reset");

        cyc("fill0", 1, 16'h1234, 16'h0001, 0, 1);
        cyc("fill1", 1, 16'h5678, 16'h0002, 0, 1);
        cyc("fill_drop", 1, 16'h9ABC, 16'h0003, 0, 1);
        cyc("fill_hold", 0, 16'h0000, 16'h0000, 0, 1);
        cyc("drain0", 0, 16'h0000, 16'h0000, 0, 0);
        cyc("drain1", 0, 16'h0000, 16'h0000, 0, 0);
        cyc("empty", 0, 16'h0000, 16'h0000, 0, 0);

        for (int k = 1; k <= 8; k++)
            cyc($sformatf("stream%0d", k), 1, 16'(k), 16'(k + 100), 0, 0);
        cyc("stream_end", 0, 16'h0000, 16'h0000, 0, 0);
        cyc("stream_idle", 0, 16'h0000, 16'h0000, 0, 0);

        cyc("fl_fill0", 1, 16'hC001, 16'h0010, 0, 1);
        cyc("fl_fill1", 1, 16'hC002, 16'h0011, 0, 1);
        cyc("fl_flush", 1, 16'hAAAA, 16'h0012, 1, 0);
        cyc("fl_after", 0, 16'h0000, 16'h0000, 0, 0);
        cyc("fl_idle", 0, 16'h0000, 16'h0000, 0, 0);

        cyc("halt_push", 1, 16'hF000, 16'h0020, 0, 1);
        cyc("halt_next", 1, 16'h1111, 16'h0021, 0, 1);
        cyc("halt_hold", 0, 16'h0000, 16'h0000, 0, 1);
        cyc("halt_flush", 0, 16'h0000, 16'h0000, 1, 0);
        cyc("halt_clear", 1, 16'h2222, 16'h0030, 0, 0);
        cyc("halt_resume", 0, 16'h0000, 16'h0000, 0, 0);

        cyc("rst_fill0", 1, 16'hD001, 16'h0040, 0, 1);
        cyc("rst_fill1", 1, 16'hD002, 16'h0041, 0, 1);
        check_outputs("rst_full");
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        halted_m = 1'b0;
        check_outputs("rst_async");
        bus.if_valid = 1'b0;
        bus.id_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc("rst_resume", 1, 16'h3333, 16'h0050, 0, 0);
        cyc("rst_final", 0, 16'h0000, 16'h0000, 0, 0);
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
